// File: rtl/keypad_scan_32.sv
// 4x4 hex keypad scanner: walks a low level across the rows, debounces whole-matrix
// snapshots and shifts each accepted key code into a 32-bit entry register.
module keypad_scan_32 #(
  parameter int SCAN_CLOCKS    = 100_000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst_i,
  output logic [3:0]  ROW,
  input  logic [3:0]  COL,
  output logic [3:0]  key_o,
  output logic        key_valid_o,
  output logic [31:0] data_o
);

  localparam int CNT_W = (SCAN_CLOCKS > 1) ? $clog2(SCAN_CLOCKS) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_CLOCKS - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD} state_t;
  typedef enum logic [1:0] {CLS_NONE, CLS_SINGLE, CLS_MULTI} cls_t;

  function automatic cls_t classify(input logic [15:0] m);
    int n;
    n = 0;
    for (int i = 0; i < 16; i++) n += int'(m[i]);
    if (n == 0) return CLS_NONE;
    if (n == 1) return CLS_SINGLE;
    return CLS_MULTI;
  endfunction

  // Map bit index is row*4+col, which is exactly the key code.
  function automatic logic [3:0] first_key(input logic [15:0] m);
    logic [3:0] k;
    k = '0;
    for (int i = 0; i < 16; i++) begin
      if (m[i]) k = 4'(i);
    end
    return k;
  endfunction

  logic [3:0]       col_sync_p0;
  logic [3:0]       col_sync_p1;
  logic [CNT_W-1:0] scan_cnt;
  logic [1:0]       row_idx;
  logic [15:0]      key_map;
  state_t           state;
  state_t           state_nxt;
  logic [3:0]       cand;
  logic [3:0]       cand_nxt;
  logic [DB_W-1:0]  stable_cnt;
  logic [DB_W-1:0]  stable_nxt;
  logic [DB_W-1:0]  rel_cnt;
  logic [DB_W-1:0]  rel_nxt;
  logic             accept;

  logic             wrap;
  logic             scan_end;
  logic [3:0]       pressed;
  logic [15:0]      full_map;
  cls_t             map_cls;
  logic [3:0]       map_code;

  // Stage p0/p1: two-flop synchroniser for the asynchronous column lines
  always_ff @(posedge clk) begin
    col_sync_p0 <= COL;
    col_sync_p1 <= col_sync_p0;
  end

  assign wrap     = (scan_cnt == CNT_LAST);
  assign scan_end = wrap && (row_idx == 2'd3);
  assign pressed  = ~col_sync_p1;
  // The row-3 slice comes straight from this cycle's sample so the scan-end
  // evaluation sees the complete current scan.
  assign full_map = {pressed, key_map[11:0]};
  assign map_cls  = classify(full_map);
  assign map_code = first_key(full_map);

  // Row scanning and key map capture
  always_ff @(posedge clk) begin
    if (rst_i) begin
      scan_cnt <= '0;
      row_idx  <= 2'd0;
      ROW      <= 4'b1110;
      key_map  <= '0;
    end else begin
      if (wrap) begin
        scan_cnt                        <= '0;
        key_map[{row_idx, 2'b00} +: 4]  <= pressed;
        row_idx                         <= row_idx + 2'd1;
        ROW                             <= {ROW[2:0], ROW[3]};
      end else begin
        scan_cnt <= scan_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    cand_nxt   = cand;
    stable_nxt = stable_cnt;
    rel_nxt    = rel_cnt;
    accept     = 1'b0;
    if (scan_end) begin
      case (state)
        IDLE: begin
          if (map_cls == CLS_SINGLE) begin
            cand_nxt = map_code;
            if (DEBOUNCE_SCANS == 1) begin
              accept    = 1'b1;
              rel_nxt   = '0;
              state_nxt = HELD;
            end else begin
              stable_nxt = DB_W'(1);
              state_nxt  = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (map_cls == CLS_SINGLE && map_code == cand) begin
            if (stable_cnt + DB_W'(1) == DB_LAST) begin
              accept    = 1'b1;
              rel_nxt   = '0;
              state_nxt = HELD;
            end else begin
              stable_nxt = stable_cnt + DB_W'(1);
            end
          end else begin
            state_nxt = IDLE;
          end
        end
        HELD: begin
          if (map_cls == CLS_NONE) begin
            if (rel_cnt + DB_W'(1) == DB_LAST) begin
              rel_nxt   = '0;
              state_nxt = IDLE;
            end else begin
              rel_nxt = rel_cnt + DB_W'(1);
            end
          end else begin
            rel_nxt = '0;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Debounce state and accepted-key outputs
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state       <= IDLE;
      cand        <= '0;
      stable_cnt  <= '0;
      rel_cnt     <= '0;
      key_o       <= '0;
      key_valid_o <= 1'b0;
      data_o      <= '0;
    end else begin
      state       <= state_nxt;
      cand        <= cand_nxt;
      stable_cnt  <= stable_nxt;
      rel_cnt     <= rel_nxt;
      key_valid_o <= accept;
      if (accept) begin
        key_o  <= cand_nxt;
        data_o <= {data_o[27:0], cand_nxt};
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_32.sv
// Bench for keypad_scan_32: a keypad model drives COL from ROW, and a scan-level
// model of the debounce rules predicts pulses, key_o and data_o.
module tb_keypad_scan_32;

  localparam int SC = 4;
  localparam int DB = 2;
  localparam int SCAN_CYC = 4 * SC;

  logic        clk;
  logic        rst_i;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_o;
  logic        key_valid_o;
  logic [31:0] data_o;
  logic [15:0] keys;

  int checks;
  int failures;
  int total_pulses;

  int          m_streak;
  logic [3:0]  m_cand;
  bit          m_held;
  int          m_rel;
  logic [3:0]  m_key;
  logic [31:0] m_data;

  keypad_scan_32 #(.SCAN_CLOCKS(SC), .DEBOUNCE_SCANS(DB)) dut (
    .clk(clk), .rst_i(rst_i), .ROW(row), .COL(col),
    .key_o(key_o), .key_valid_o(key_valid_o), .data_o(data_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row[r]) col[c] = 1'b0;
  end

  task automatic model_reset();
    m_streak = 0; m_cand = 4'h0; m_held = 0; m_rel = 0; m_key = 4'h0; m_data = 32'h0;
  endtask

  task automatic model_scan(input logic [15:0] ks, output bit acc);
    int n;
    logic [3:0] code;
    n = $countones(ks);
    code = 4'h0;
    acc = 0;
    for (int i = 0; i < 16; i++) if (ks[i]) code = 4'(i);
    if (m_held) begin
      if (n == 0) begin
        m_rel++;
        if (m_rel >= DB) begin m_held = 0; m_rel = 0; end
      end else m_rel = 0;
    end else if (n == 1) begin
      if (m_streak == 0) begin m_cand = code; m_streak = 1; end
      else if (code == m_cand) m_streak++;
      else m_streak = 0;
      if (m_streak >= DB) begin
        acc = 1; m_streak = 0; m_held = 1; m_rel = 0;
        m_key = m_cand; m_data = {m_data[27:0], m_cand};
      end
    end else m_streak = 0;
  endtask

  task automatic run_scan(input logic [15:0] ks);
    bit acc;
    int pulses;
    keys = ks;
    model_scan(ks, acc);
    pulses = 0;
    for (int i = 0; i < SCAN_CYC; i++) begin
      @(posedge clk); #1;
      if (key_valid_o === 1'b1) pulses++;
    end
    total_pulses += pulses;
    checks++;
    if (pulses !== int'(acc)) begin
      failures++;
      $display("FAIL scan_pulses keys=%h got=%0d exp=%0d", ks, pulses, int'(acc));
    end
    checks++;
    if (key_valid_o !== acc) begin
      failures++;
      $display("FAIL pulse_timing keys=%h got=%b exp=%b", ks, key_valid_o, acc);
    end
    checks++;
    if (key_o !== m_key) begin
      failures++;
      $display("FAIL scan_key keys=%h got=%h exp=%h", ks, key_o, m_key);
    end
    checks++;
    if (data_o !== m_data) begin
      failures++;
      $display("FAIL scan_data keys=%h got=%h exp=%h", ks, data_o, m_data);
    end
  endtask

  task automatic run_scans(input logic [15:0] ks, input int n);
    for (int i = 0; i < n; i++) run_scan(ks);
  endtask

  task automatic do_reset(input int n);
    rst_i = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    checks++;
    if (row !== 4'b1110 || key_o !== 4'h0 || key_valid_o !== 1'b0 || data_o !== 32'h0) begin
      failures++;
      $display("FAIL reset_values got=%b/%h/%b/%h exp=1110/0/0/00000000",
               row, key_o, key_valid_o, data_o);
    end
    rst_i = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    logic [3:0] exp_row;
    keys = 16'h0;
    do_reset(3);
    for (int i = 1; i <= SCAN_CYC; i++) begin
      @(posedge clk); #1;
      exp_row = ~(4'b0001 << ((i / SC) % 4));
      checks++;
      if (row !== exp_row) begin
        failures++;
        $display("FAIL row_rotate cycle=%0d got=%b exp=%b", i, row, exp_row);
      end
      checks++;
      if (key_valid_o !== 1'b0) begin
        failures++;
        $display("FAIL idle_pulse cycle=%0d got=%b exp=0", i, key_valid_o);
      end
    end
  endtask

  task automatic test_single_press();
    int p0;
    do_reset(1);
    p0 = total_pulses;
    run_scans(16'h0200, 5);
    run_scans(16'h0000, 3);
    checks++;
    if (total_pulses - p0 !== 1) begin
      failures++;
      $display("FAIL single_pulse_count got=%0d exp=1", total_pulses - p0);
    end
    checks++;
    if (key_o !== 4'h9 || data_o !== 32'h00000009) begin
      failures++;
      $display("FAIL single_key got=%h/%h exp=9/00000009", key_o, data_o);
    end
  endtask

  task automatic test_sequence();
    int p0;
    do_reset(1);
    p0 = total_pulses;
    for (int k = 1; k <= 8; k++) begin
      run_scans(16'h0001 << k, 3);
      run_scans(16'h0000, 3);
    end
    checks++;
    if (data_o !== 32'h12345678) begin
      failures++;
      $display("FAIL seq_data got=%h exp=12345678", data_o);
    end
    run_scans(16'h0400, 3);
    run_scans(16'h0000, 3);
    checks++;
    if (data_o !== 32'h2345678A || key_o !== 4'hA) begin
      failures++;
      $display("FAIL seq_data_a got=%h/%h exp=2345678a/a", data_o, key_o);
    end
    checks++;
    if (total_pulses - p0 !== 9) begin
      failures++;
      $display("FAIL seq_pulses got=%0d exp=9", total_pulses - p0);
    end
  endtask

  task automatic test_glitches();
    int p0;
    do_reset(1);
    p0 = total_pulses;
    run_scans(16'h0040, 1);
    run_scans(16'h0000, 3);
    checks++;
    if (total_pulses - p0 !== 0) begin
      failures++;
      $display("FAIL short_press got=%0d exp=0", total_pulses - p0);
    end
    run_scans(16'h0008, 3);
    run_scans(16'h0000, 1);
    run_scans(16'h0008, 3);
    checks++;
    if (total_pulses - p0 !== 1) begin
      failures++;
      $display("FAIL bounce_release got=%0d exp=1", total_pulses - p0);
    end
    run_scans(16'h0000, 3);
    run_scans(16'h0008, 3);
    checks++;
    if (total_pulses - p0 !== 2) begin
      failures++;
      $display("FAIL full_release got=%0d exp=2", total_pulses - p0);
    end
    run_scans(16'h0000, 3);
  endtask

  task automatic test_multi();
    int p0;
    do_reset(1);
    run_scans(16'h0007 << 4, 0);
    p0 = total_pulses;
    run_scans(16'h8001, 4);
    checks++;
    if (total_pulses - p0 !== 0) begin
      failures++;
      $display("FAIL multi_reject got=%0d exp=0", total_pulses - p0);
    end
    run_scans(16'h0001, 2);
    checks++;
    if (total_pulses - p0 !== 1 || data_o[3:0] !== 4'h0 || key_o !== 4'h0) begin
      failures++;
      $display("FAIL multi_then_single got=%0d/%h exp=1/0", total_pulses - p0, data_o[3:0]);
    end
    run_scans(16'h0000, 3);
  endtask

  task automatic test_reset_held();
    do_reset(1);
    run_scans(16'h0020, 3);
    keys = 16'h0020;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checks++;
      if (key_valid_o !== 1'b0) begin
        failures++;
        $display("FAIL held_no_repeat got=%b exp=0", key_valid_o);
      end
    end
    do_reset(1);
    run_scans(16'h0020, 2);
    checks++;
    if (data_o !== 32'h00000005 || key_o !== 4'h5) begin
      failures++;
      $display("FAIL reaccept got=%h/%h exp=00000005/5", data_o, key_o);
    end
    run_scans(16'h0000, 3);
  endtask

  task automatic test_random();
    logic [15:0] ks;
    logic [3:0]  prev;
    int sel, a, b;
    do_reset(1);
    prev = 4'($urandom_range(0, 15));
    for (int s = 0; s < 80; s++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 3) ks = 16'h0;
      else if (sel <= 7) ks = 16'h0001 << prev;
      else if (sel == 8) begin
        prev = 4'($urandom_range(0, 15));
        ks = 16'h0001 << prev;
      end else begin
        a = $urandom_range(0, 15);
        b = (a + 1 + $urandom_range(0, 14)) % 16;
        ks = (16'h0001 << a) | (16'h0001 << b);
      end
      run_scan(ks);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    total_pulses = 0;
    rst_i = 1'b1;
    keys = 16'h0;
    model_reset();
    test_reset();
    test_single_press();
    test_sequence();
    test_glitches();
    test_multi();
    test_reset_held();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
